// File: rtl/bist_seq.sv
// Built-in self-test sequencer. Generates pseudo-random operand vectors from an
// 8-bit LFSR and drives them to an external datapath. It compares the datapath's
// A/B results against golden values computed locally, then reports the pass/fail
// status, the number of failing vectors and the index of the first failing vector.
module bist_seq #(
    parameter int         K1      = 3,
    parameter int         K2      = 5,
    parameter int         NUM_VEC = 16,
    parameter int         DUT_LAT = 1,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dut_a,
    input  logic [15:0] dut_b,
    output logic [7:0]  x1,
    output logic [7:0]  x2,
    output logic [7:0]  v,
    output logic [7:0]  t,
    output logic [7:0]  c,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [7:0]  first_fail
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);
    localparam logic [3:0] LAT_INIT = 4'(DUT_LAT - 1);
    localparam logic [7:0] NO_FAIL  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t      state_reg;
    logic [7:0]  lfsr_reg;
    logic [7:0]  vec_idx_reg;
    logic [3:0]  wait_cnt_reg;

    logic [7:0]  lfsr_next;
    logic [7:0]  load_l;
    logic [7:0]  load_idx;
    logic [7:0]  x1_next;
    logic [7:0]  x2_next;
    logic [7:0]  v_next;
    logic [7:0]  t_next;
    logic [7:0]  c_next;
    logic [15:0] gold_a;
    logic [15:0] gold_b;
    logic        mismatch;
    logic [7:0]  fail_count_next;

    // Fibonacci step for x^8+x^6+x^5+x^4+1: shift left, XOR of taps into bit 0.
    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

    // Golden results. The operands are zero-extended to 16 bits. The largest
    // possible sums (2040 and 65280) fit in 16 bits, so nothing is lost.
    assign gold_a = 16'(x1) * 16'(K1) + 16'(x2) * 16'(K2);
    assign gold_b = 16'(v) * 16'(t) + 16'(c);

    // A vector that fails on A, on B or on both is counted once.
    assign mismatch = (dut_a != gold_a) || (dut_b != gold_b);

    // The fail counter saturates at 255 rather than wrapping.
    assign fail_count_next = (mismatch && (fail_count != 8'hFF)) ? fail_count + 8'd1 : fail_count;

    // Choose the LFSR value and index for the next vector to load. A new run
    // starts from the seed at index 0. Moving from CHECK to the next DRIVE uses
    // the advanced LFSR value and the incremented index.
    always_comb begin
        load_l   = SEED_EFF;
        load_idx = 8'd0;
        if (state_reg == CHECK) begin
            load_l   = lfsr_next;
            load_idx = vec_idx_reg + 8'd1;
        end
        x1_next = load_l;
        x2_next = ~load_l;
        v_next  = {load_l[3:0], load_l[7:4]};
        t_next  = load_l ^ 8'hA5;
        c_next  = load_l + load_idx;
    end

    // Sequencer FSM. All outputs are registered here. The operands are loaded on
    // the edge that enters DRIVE, so they stay valid from DRIVE through CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            lfsr_reg     <= SEED_EFF;
            vec_idx_reg  <= 8'd0;
            wait_cnt_reg <= 4'd0;
            x1           <= 8'd0;
            x2           <= 8'd0;
            v            <= 8'd0;
            t            <= 8'd0;
            c            <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_count   <= 8'd0;
            first_fail   <= NO_FAIL;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg   <= DRIVE;
                        lfsr_reg    <= SEED_EFF;
                        vec_idx_reg <= 8'd0;
                        fail_count  <= 8'd0;
                        first_fail  <= NO_FAIL;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        x1          <= x1_next;
                        x2          <= x2_next;
                        v           <= v_next;
                        t           <= t_next;
                        c           <= c_next;
                    end
                end
                DRIVE: begin
                    state_reg    <= WAIT;
                    wait_cnt_reg <= LAT_INIT;
                end
                WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= CHECK;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                CHECK: begin
                    lfsr_reg   <= lfsr_next;
                    fail_count <= fail_count_next;
                    if (mismatch && (first_fail == NO_FAIL)) begin
                        first_fail <= vec_idx_reg;
                    end
                    if (vec_idx_reg < LAST_IDX) begin
                        state_reg   <= DRIVE;
                        vec_idx_reg <= vec_idx_reg + 8'd1;
                        x1          <= x1_next;
                        x2          <= x2_next;
                        v           <= v_next;
                        t           <= t_next;
                        c           <= c_next;
                    end else begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (fail_count_next == 8'd0);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_seq.sv
// Testbench for bist_seq. It uses three instances: default parameters,
// NUM_VEC=255 with a stuck-at-zero datapath, and DUT_LAT=4 with SEED=0.
// Expected operand vectors come from an LFSR model in the bench and are
// queued when a run starts. They are popped when each DRIVE cycle is reached.
module tb_bist_seq;

    localparam int K1 = 3;
    localparam int K2 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Datapath model controls for instance 1
    int fault_mode = 0;
    int cur_vec    = 0;

    logic [39:0] sb_q[$];

    // ---------------- instance 1: defaults ----------------
    logic        start_1;
    logic [15:0] dut_a_1, dut_b_1;
    logic [7:0]  x1_1, x2_1, v_1, t_1, c_1, fc_1, ff_1;
    logic        busy_1, done_1, pass_1;

    bist_seq u1 (
        .clk(clk), .rst(rst), .start(start_1), .dut_a(dut_a_1), .dut_b(dut_b_1),
        .x1(x1_1), .x2(x2_1), .v(v_1), .t(t_1), .c(c_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .fail_count(fc_1), .first_fail(ff_1)
    );

    // ---------------- instance 2: 255 vectors, stuck datapath ----------------
    logic        start_2;
    logic [15:0] dut_a_2, dut_b_2;
    logic [7:0]  x1_2, x2_2, v_2, t_2, c_2, fc_2, ff_2;
    logic        busy_2, done_2, pass_2;

    assign dut_a_2 = 16'h0000;
    assign dut_b_2 = 16'h0000;

    bist_seq #(.NUM_VEC(255)) u2 (
        .clk(clk), .rst(rst), .start(start_2), .dut_a(dut_a_2), .dut_b(dut_b_2),
        .x1(x1_2), .x2(x2_2), .v(v_2), .t(t_2), .c(c_2),
        .busy(busy_2), .done(done_2), .pass(pass_2), .fail_count(fc_2), .first_fail(ff_2)
    );

    // ---------------- instance 3: latency 4, zero seed ----------------
    logic        start_3;
    logic [15:0] dut_a_3, dut_b_3;
    logic [7:0]  x1_3, x2_3, v_3, t_3, c_3, fc_3, ff_3;
    logic        busy_3, done_3, pass_3;

    bist_seq #(.DUT_LAT(4), .SEED(8'h00)) u3 (
        .clk(clk), .rst(rst), .start(start_3), .dut_a(dut_a_3), .dut_b(dut_b_3),
        .x1(x1_3), .x2(x2_3), .v(v_3), .t(t_3), .c(c_3),
        .busy(busy_3), .done(done_3), .pass(pass_3), .fail_count(fc_3), .first_fail(ff_3)
    );

    function automatic logic [15:0] gold_a(input logic [7:0] a, input logic [7:0] b);
        return 16'(a) * 16'(K1) + 16'(b) * 16'(K2);
    endfunction

    function automatic logic [15:0] gold_b(input logic [7:0] vv, input logic [7:0] tt, input logic [7:0] cc);
        return 16'(vv) * 16'(tt) + 16'(cc);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // One-cycle-latency datapath model with selectable injected faults
    always @(posedge clk) begin
        logic [15:0] ga, gb;
        ga = gold_a(x1_1, x2_1);
        gb = gold_b(v_1, t_1, c_1);
        if (fault_mode == 1 && cur_vec == 3) gb = gb ^ 16'h8000;
        if (fault_mode == 2) begin
            ga = 16'h0000;
            gb = 16'h0000;
        end
        if (fault_mode == 3 && (cur_vec == 2 || cur_vec == 7)) ga = ga ^ 16'h0100;
        if (fault_mode == 3 && cur_vec == 7) gb = gb ^ 16'h0001;
        dut_a_1 <= ga;
        dut_b_1 <= gb;
    end

    // Four-stage correct datapath model for instance 3
    logic [31:0] pipe3 [4];
    always @(posedge clk) begin
        pipe3[0] <= {gold_a(x1_3, x2_3), gold_b(v_3, t_3, c_3)};
        for (int i = 1; i < 4; i++) pipe3[i] <= pipe3[i-1];
    end
    assign dut_a_3 = pipe3[3][31:16];
    assign dut_b_3 = pipe3[3][15:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic void push_expected(input logic [7:0] seed, input int n);
        logic [7:0] l;
        l = (seed == 8'h00) ? 8'h01 : seed;
        for (int k = 0; k < n; k++) begin
            sb_q.push_back({l, ~l, l[3:0], l[7:4], l ^ 8'hA5, 8'(l + 8'(k))});
            l = lfsr_step(l);
        end
    endfunction

    task automatic pop_cmp(input string name, input logic [39:0] act, output logic [39:0] exp);
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            exp = 40'h0;
            $display("FAIL %s: scoreboard empty, got %0h", name, act);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %0h, want %0h", name, act, exp);
            end
        end
    endtask

    typedef struct {
        int         fault;
        int         gl_vec;
        int         gl_phase;
        logic       exp_pass;
        logic [7:0] exp_fc;
        logic [7:0] exp_ff;
    } test_t;

    // A full 16-vector run on instance 1. It optionally pulses start during
    // one phase (0=DRIVE, 1=WAIT, 2=CHECK) of one vector; that pulse must be ignored.
    task automatic run_a(input int idx, input test_t tc);
        logic [39:0] exp;
        fault_mode = tc.fault;
        push_expected(8'hA5, 16);
        @(negedge clk); start_1 = 1'b1;
        @(negedge clk); start_1 = 1'b0;
        check("start_busy", busy_1, 1'b1);
        check("start_done_low", done_1, 1'b0);
        exp = 40'h0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (j == 0) begin
                    cur_vec = k;
                    pop_cmp("operands", {x1_1, x2_1, v_1, t_1, c_1}, exp);
                end else begin
                    check("operands_hold", {x1_1, x2_1, v_1, t_1, c_1}, exp);
                end
                if (k == 15 && j == 2) check("done_early", done_1, 1'b0);
                if (k == tc.gl_vec && j == tc.gl_phase) start_1 = 1'b1;
                @(negedge clk);
                start_1 = 1'b0;
            end
        end
        check("done_at_48", done_1, 1'b1);
        check("busy_end", busy_1, 1'b0);
        check("pass", pass_1, tc.exp_pass);
        check("fail_count", fc_1, tc.exp_fc);
        check("first_fail", ff_1, tc.exp_ff);
        $display("run %0d fault=%0d glitch=%0d/%0d fail_count=%0d first_fail=%h pass=%b",
                 idx, tc.fault, tc.gl_vec, tc.gl_phase, fc_1, ff_1, pass_1);
    endtask

    test_t tests [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] exp;
        tests[0] = '{0, -1, -1, 1'b1, 8'd0,  8'hFF};
        tests[1] = '{1, -1, -1, 1'b0, 8'd1,  8'h03};
        tests[2] = '{2, -1, -1, 1'b0, 8'd16, 8'h00};
        tests[3] = '{3, -1, -1, 1'b0, 8'd2,  8'h02};
        tests[4] = '{0,  4,  2, 1'b1, 8'd0,  8'hFF};
        tests[5] = '{0,  9,  1, 1'b1, 8'd0,  8'hFF};
        tests[6] = '{0, 12,  0, 1'b1, 8'd0,  8'hFF};

        rst = 1'b1;
        start_1 = 1'b0;
        start_2 = 1'b0;
        start_3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ops", {x1_1, x2_1, v_1, t_1, c_1}, 40'h0);
        check("rst_flags", {busy_1, done_1, pass_1}, 3'b000);
        check("rst_fc", fc_1, 8'd0);
        check("rst_ff", ff_1, 8'hFF);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy_1, 1'b0);

        // Table-driven runs on the default instance
        for (int i = 0; i < 7; i++) run_a(i, tests[i]);

        // Abort a run with reset during WAIT of vector 5, then restart it
        fault_mode = 0;
        push_expected(8'hA5, 16);
        @(negedge clk); start_1 = 1'b1;
        @(negedge clk); start_1 = 1'b0;
        repeat (16) @(negedge clk);
        check("midrun_busy", busy_1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_ops", {x1_1, x2_1, v_1, t_1, c_1}, 40'h0);
        check("abort_flags", {busy_1, done_1, pass_1}, 3'b000);
        check("abort_fc", fc_1, 8'd0);
        check("abort_ff", ff_1, 8'hFF);
        sb_q.delete();
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", {busy_1, done_1, pass_1}, 3'b000);
        run_a(7, tests[0]);
        check("after_abort_x1", x1_1 == 8'hA5 ? 1'b0 : 1'b1, 1'b1);

        // Latency 4, zero seed: 96-cycle run
        push_expected(8'h00, 2);
        @(negedge clk); start_3 = 1'b1;
        @(negedge clk); start_3 = 1'b0;
        check("lat4_x1", x1_3, 8'h01);
        pop_cmp("lat4_vec0", {x1_3, x2_3, v_3, t_3, c_3}, exp);
        repeat (6) @(negedge clk);
        pop_cmp("lat4_vec1", {x1_3, x2_3, v_3, t_3, c_3}, exp);
        repeat (89) @(negedge clk);
        check("lat4_done_early", done_3, 1'b0);
        @(negedge clk);
        check("lat4_done_96", done_3, 1'b1);
        check("lat4_pass", pass_3, 1'b1);
        check("lat4_fc", fc_3, 8'd0);
        check("lat4_ff", ff_3, 8'hFF);
        $display("run lat4 fail_count=%0d first_fail=%h pass=%b", fc_3, ff_3, pass_3);

        // 255 vectors against a stuck datapath: the counter must stop at 255
        @(negedge clk); start_2 = 1'b1;
        @(negedge clk); start_2 = 1'b0;
        repeat (764) @(negedge clk);
        check("n255_done_early", done_2, 1'b0);
        @(negedge clk);
        check("n255_done", done_2, 1'b1);
        check("n255_fc", fc_2, 8'd255);
        check("n255_ff", ff_2, 8'h00);
        check("n255_pass", pass_2, 1'b0);
        $display("run n255 fail_count=%0d first_fail=%h pass=%b", fc_2, ff_2, pass_2);

        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bist_seq.md
BIST_SEQ -- requirements
Module: bist_seq

Interface
REQ-001 Parameter K1, default 3, multiplier weight for x1 in golden A.
REQ-002 Parameter K2, default 5, multiplier weight for x2 in golden A.
REQ-003 Parameter NUM_VEC, default 16, vectors per run (1..255).
REQ-004 Parameter DUT_LAT, default 1, cycles from vector drive to valid dut_a/dut_b (1..15).
REQ-005 Parameter SEED, default 8'hA5, LFSR start value; a SEED of 0 SHALL be loaded as 8'h01.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 start  in  1  single-cycle run request.
REQ-010 dut_a  in  16  A result from datapath under test.
REQ-011 dut_b  in  16  B result from datapath under test.
REQ-012 x1, x2, v, t, c  out  8 each  registered test operands to datapath.
REQ-013 busy  out  1  high while a run is in progress.
REQ-014 done  out  1  high from run completion until next start or reset.
REQ-015 pass  out  1  done AND fail_count==0.
REQ-016 fail_count  out  8  mismatching vectors, saturating at 255.
REQ-017 first_fail  out  8  index of first mismatching vector; 8'hFF if none.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-019 IDLE->DRIVE on start; DONE->DRIVE on start; start in DRIVE/WAIT/CHECK SHALL be ignored.
REQ-020 Starting a run SHALL reload LFSR with SEED, clear vec_idx, fail_count, first_fail=8'hFF, done=0.
REQ-021 DRIVE (1 cycle) SHALL register operands from LFSR value L: x1=L, x2=~L, v={L[3:0],L[7:4]}, t=L^8'hA5, c=L+vec_idx (mod 256).
REQ-022 WAIT SHALL last exactly DUT_LAT cycles via down-counter, then go to CHECK.
REQ-023 Operands SHALL stay constant from DRIVE through CHECK.
REQ-024 Golden values, 16-bit unsigned, no truncation: gA=x1*K1+x2*K2, gB=v*t+c.
REQ-025 CHECK (1 cycle) SHALL flag mismatch if dut_a!=gA or dut_b!=gB; one vector counts once even if both differ.
REQ-026 On mismatch fail_count SHALL increment unless 255; first_fail SHALL capture vec_idx only if still 8'hFF.
REQ-027 In CHECK the LFSR SHALL advance one step, Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
REQ-028 CHECK->DRIVE with vec_idx+1 if vec_idx<NUM_VEC-1, else CHECK->DONE.
REQ-029 Run length SHALL be NUM_VEC*(DUT_LAT+2) cycles from first DRIVE to DONE entry.
REQ-030 busy SHALL be high in DRIVE, WAIT, CHECK only; done SHALL be high only in DONE.

Reset
REQ-031 On rst, asynchronously: state=IDLE, all operands=0, vec_idx=0, fail_count=0, first_fail=8'hFF, busy=0, done=0, pass=0, LFSR=SEED (or 8'h01).
REQ-032 rst mid-run SHALL abort the run with no partial done/pass; the next start SHALL begin at vector 0.

Verification
REQ-033 Defaults, correct DUT model with latency 1, start pulse -> first DRIVE x1=A5, x2=5A, v=5A, t=00, c=A5; gA=16'h03B1, gB=16'h00A5; done after 48 cycles, pass=1, fail_count=0, first_fail=FF.
REQ-034 DUT model forces dut_b wrong on vector 3 only -> done, pass=0, fail_count=1, first_fail=03.
REQ-035 DUT stuck at 0 for all 16 vectors -> fail_count=16, first_fail=00; NUM_VEC=255 with stuck DUT -> fail_count=255, no wrap.
REQ-036 rst asserted in WAIT of vector 5 -> all outputs at reset values same cycle; new start reruns from vector 0 with x1=A5.
REQ-037 start pulsed during CHECK -> ignored, run completes in 48 cycles; start in DONE -> new run, done drops next cycle.
REQ-038 DUT_LAT=4, SEED=0 -> first x1=01, run length 16*6=96 cycles, pass=1 with correct DUT.
